// File: rtl/reg_file_wb_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : reg_file_wb_pkg
//  Brief   : Shared register-file geometry and ALU select encodings.
//  Rev     : 1.0  initial release
// ============================================================================
package reg_file_wb_pkg;

    localparam int REG_WIDTH  = 8;
    localparam int REG_COUNT  = 8;
    localparam int REG_ADDR_W = $clog2(REG_COUNT);

    typedef enum logic [2:0] {
        ALU_FORWARD = 3'b000,
        ALU_ADD     = 3'b001,
        ALU_AND     = 3'b010,
        ALU_OR      = 3'b011
    } alu_sel_e;

endpackage
`default_nettype wire

// File: rtl/reg_bypass_mux.sv
`default_nettype none
// ============================================================================
//  Module  : reg_bypass_mux
//  Brief   : Per-port select between the pending write-back and the array.
//  Rev     : 1.0  initial release
// ============================================================================
module reg_bypass_mux #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              i_wb_valid,
    input  logic [ADDR_W-1:0] i_wb_addr,
    input  logic [WIDTH-1:0]  i_wb_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    input  logic [WIDTH-1:0]  i_arr_data,
    output logic [WIDTH-1:0]  o_rd_data
);

    logic w_hit;

    assign w_hit     = i_wb_valid && (i_wb_addr == i_rd_addr);
    assign o_rd_data = w_hit ? i_wb_data : i_arr_data;

endmodule
`default_nettype wire

// File: rtl/reg_file_wb.sv
`default_nettype none
// ============================================================================
//  Module  : reg_file_wb
//  Brief   : 8x8 register file with a one-entry bypassed write-back stage.
//  Rev     : 1.0  initial release
// ============================================================================
module reg_file_wb
    import reg_file_wb_pkg::*;
#(
    parameter int WIDTH = REG_WIDTH,
    parameter int NREGS = REG_COUNT
) (
    input  logic                     CLK,
    input  logic                     RESETN,
    input  logic [WIDTH-1:0]         IN,
    input  logic [$clog2(NREGS)-1:0] INADDRESS,
    input  logic                     WRITEENABLE,
    input  logic [$clog2(NREGS)-1:0] OUT1ADDRESS,
    input  logic [$clog2(NREGS)-1:0] OUT2ADDRESS,
    output logic [WIDTH-1:0]         OUT1,
    output logic [WIDTH-1:0]         OUT2,
    output logic                     WB_PENDING
);

    localparam int c_ADDR_W = $clog2(NREGS);

    logic                r_wb_valid;
    logic [c_ADDR_W-1:0] r_wb_addr;
    logic [WIDTH-1:0]    r_wb_data;
    logic [WIDTH-1:0]    w_regs [NREGS];

    // Capture is unconditional; r_wb_valid alone decides whether it matters.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_wb_valid <= 1'b0;
            r_wb_addr  <= '0;
            r_wb_data  <= '0;
        end else begin
            r_wb_valid <= WRITEENABLE;
            r_wb_addr  <= INADDRESS;
            r_wb_data  <= IN;
        end
    end

    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_regs
            logic [WIDTH-1:0] r_q;

            always_ff @(posedge CLK or negedge RESETN) begin
                if (!RESETN) begin
                    r_q <= '0;
                end else if (r_wb_valid && (r_wb_addr == c_ADDR_W'(gi))) begin
                    r_q <= r_wb_data;
                end
            end

            assign w_regs[gi] = r_q;
        end
    endgenerate

    reg_bypass_mux #(
        .WIDTH  (WIDTH),
        .ADDR_W (c_ADDR_W)
    ) u_rd1 (
        .i_wb_valid (r_wb_valid),
        .i_wb_addr  (r_wb_addr),
        .i_wb_data  (r_wb_data),
        .i_rd_addr  (OUT1ADDRESS),
        .i_arr_data (w_regs[OUT1ADDRESS]),
        .o_rd_data  (OUT1)
    );

    reg_bypass_mux #(
        .WIDTH  (WIDTH),
        .ADDR_W (c_ADDR_W)
    ) u_rd2 (
        .i_wb_valid (r_wb_valid),
        .i_wb_addr  (r_wb_addr),
        .i_wb_data  (r_wb_data),
        .i_rd_addr  (OUT2ADDRESS),
        .i_arr_data (w_regs[OUT2ADDRESS]),
        .o_rd_data  (OUT2)
    );

    assign WB_PENDING = r_wb_valid;

endmodule
`default_nettype wire

// File: tb/tb_reg_file_wb.sv
`default_nettype none
// ============================================================================
//  Module  : tb_reg_file_wb
//  Brief   : Self-checking bench for reg_file_wb against a visible-value model.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_reg_file_wb;
    import reg_file_wb_pkg::*;

    logic       CLK = 1'b0;
    logic       RESETN;
    logic [7:0] IN;
    logic [2:0] INADDRESS;
    logic       WRITEENABLE;
    logic [2:0] OUT1ADDRESS;
    logic [2:0] OUT2ADDRESS;
    logic [7:0] OUT1;
    logic [7:0] OUT2;
    logic       WB_PENDING;

    int n_checks = 0;
    int n_errors = 0;

    // What any read of an address must return: the newest value ever
    // requested for it since reset, regardless of commit progress.
    logic [7:0] model_val [8];
    logic       model_pend;

    reg_file_wb dut (
        .CLK         (CLK),
        .RESETN      (RESETN),
        .IN          (IN),
        .INADDRESS   (INADDRESS),
        .WRITEENABLE (WRITEENABLE),
        .OUT1ADDRESS (OUT1ADDRESS),
        .OUT2ADDRESS (OUT2ADDRESS),
        .OUT1        (OUT1),
        .OUT2        (OUT2),
        .WB_PENDING  (WB_PENDING)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] alu(input alu_sel_e sel, input logic [7:0] a, input logic [7:0] b);
        case (sel)
            ALU_ADD: return a + b;
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            default: return b;
        endcase
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 8; i++) model_val[i] = 8'h00;
        model_pend = 1'b0;
    endtask

    // Inputs are stable here; one rising edge, then settle 1 ns past it.
    task automatic clock_edge();
        logic       we;
        logic [2:0] a;
        logic [7:0] d;
        we = WRITEENABLE;
        a  = INADDRESS;
        d  = IN;
        @(posedge CLK);
        if (we) model_val[a] = d;
        model_pend = we;
        #1;
    endtask

    task automatic write(input logic [2:0] a, input logic [7:0] d);
        WRITEENABLE = 1'b1;
        INADDRESS   = a;
        IN          = d;
        clock_edge();
    endtask

    task automatic idle();
        WRITEENABLE = 1'b0;
        INADDRESS   = 3'($urandom);
        IN          = 8'($urandom);
        clock_edge();
    endtask

    task automatic check_model(input string tag);
        check({tag, "_out1"}, OUT1, model_val[OUT1ADDRESS]);
        check({tag, "_out2"}, OUT2, model_val[OUT2ADDRESS]);
        check({tag, "_pend"}, {7'd0, WB_PENDING}, {7'd0, model_pend});
    endtask

    initial begin
        logic [7:0] res;

        RESETN      = 1'b1;
        IN          = 8'h00;
        INADDRESS   = 3'd0;
        WRITEENABLE = 1'b0;
        OUT1ADDRESS = 3'd0;
        OUT2ADDRESS = 3'd0;

        // Asynchronous reset asserted mid-cycle.
        #12;
        RESETN = 1'b0;
        #1;
        model_clear();
        for (int i = 0; i < 8; i++) begin
            OUT1ADDRESS = 3'(i);
            OUT2ADDRESS = 3'(7 - i);
            #1;
            check("rst_out1", OUT1, 8'h00);
            check("rst_out2", OUT2, 8'h00);
        end
        check("rst_pend", {7'd0, WB_PENDING}, 8'h00);
        @(negedge CLK);
        RESETN = 1'b1;

        // Write then read: bypass after E, array after E+1.
        OUT1ADDRESS = 3'd3;
        write(3'd3, 8'h2A);
        check("wr_bypass", OUT1, 8'h2A);
        check("wr_pend1", {7'd0, WB_PENDING}, 8'h01);
        idle();
        check("wr_array", OUT1, 8'h2A);
        check("wr_pend0", {7'd0, WB_PENDING}, 8'h00);

        // Back-to-back writes to the same address.
        OUT2ADDRESS = 3'd5;
        write(3'd5, 8'h11);
        check("b2b_e0", OUT2, 8'h11);
        write(3'd5, 8'h22);
        check("b2b_e1", OUT2, 8'h22);
        idle();
        check("b2b_e2", OUT2, 8'h22);
        idle();
        check("b2b_settled", OUT2, 8'h22);

        // Dual-port: one committed operand, one pending.
        write(3'd1, 8'h05);
        idle();
        write(3'd2, 8'h07);
        OUT1ADDRESS = 3'd1;
        OUT2ADDRESS = 3'd2;
        #1;
        check("dual_r1", OUT1, 8'h05);
        check("dual_r2", OUT2, 8'h07);
        OUT1ADDRESS = 3'd2;
        #1;
        check("same_p1", OUT1, 8'h07);
        check("same_p2", OUT2, 8'h07);
        idle();

        // Reset while a write is pending: that write is lost.
        write(3'd4, 8'hFF);
        OUT1ADDRESS = 3'd4;
        #2;
        RESETN = 1'b0;
        #1;
        model_clear();
        check("midrst_out", OUT1, 8'h00);
        check("midrst_pend", {7'd0, WB_PENDING}, 8'h00);
        @(negedge CLK);
        RESETN = 1'b1;
        idle();
        check("midrst_lost", OUT1, 8'h00);
        OUT2ADDRESS = 3'd5;
        #1;
        check("midrst_r5", OUT2, 8'h00);

        // ALU loop with a dependent instruction and no stall.
        write(3'd1, 8'h0C);
        write(3'd2, 8'h0A);
        OUT1ADDRESS = 3'd1;
        OUT2ADDRESS = 3'd2;
        #1;
        res = alu(ALU_ADD, OUT1, OUT2);
        check("alu_add", res, 8'h16);
        write(3'd3, res);
        WRITEENABLE = 1'b0;
        OUT1ADDRESS = 3'd3;
        OUT2ADDRESS = 3'd2;
        #1;
        res = alu(ALU_AND, OUT1, OUT2);
        check("alu_and", res, 8'h02);
        idle();

        // Randomized traffic with occasional asynchronous resets.
        for (int n = 0; n < 400; n++) begin
            WRITEENABLE = ($urandom_range(0, 3) != 0);
            INADDRESS   = 3'($urandom);
            IN          = 8'($urandom);
            OUT1ADDRESS = 3'($urandom);
            OUT2ADDRESS = ($urandom_range(0, 3) == 0) ? INADDRESS : 3'($urandom);
            #1;
            check_model("rnd_pre");
            clock_edge();
            OUT1ADDRESS = 3'($urandom);
            OUT2ADDRESS = 3'($urandom);
            #1;
            check_model("rnd_post");
            if ($urandom_range(0, 49) == 0) begin
                #1;
                RESETN = 1'b0;
                #1;
                model_clear();
                check_model("rnd_rst");
                @(negedge CLK);
                RESETN = 1'b1;
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
